// File: rtl/pzbcm_stream_demux.sv
`default_nettype none
//==============================================================================
// Module      : pzbcm_stream_demux
// Description : 1-to-ENTRIES valid/ready stream router. Each packet is
//               steered to the output named by i_select on its first beat.
//               That destination is held until the last beat. A 2-entry
//               FIFO sits between the input and the outputs. It gives full
//               throughput, and o_ready depends only on registered state.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
// Parameters
//   WIDTH        payload width in bits
//   ENTRIES      number of output streams (>= 2)
//   COUNT_WIDTH  width of the dropped-beat counter
//   INDEX_WIDTH  (derived) width of the destination index
//
// Ports
//   i_clk         clock
//   i_rst_n       asynchronous active-low reset
//   i_valid       input beat valid
//   o_ready       input beat accepted when i_valid & o_ready
//   i_select      destination index, sampled on the first beat of a packet
//   i_data        input payload
//   i_last        last beat of packet
//   o_valid       per-output valid (at most one bit set)
//   i_ready       per-output ready
//   o_data        per-output payload; every lane carries the head data
//   o_last        per-output last; every lane carries the head last flag
//   o_drop_count  count of discarded (out-of-range) beats
//
// Build option
//   PZBCM_STREAM_DEMUX_DROP_COUNTER_EN
//     defined   : o_drop_count counts discarded beats and saturates at all-ones
//     undefined : no counter register; o_drop_count is tied to zero
//==============================================================================
module pzbcm_stream_demux #(
    parameter  int WIDTH       = 32,
    parameter  int ENTRIES     = 4,
    parameter  int COUNT_WIDTH = 16,
    localparam int INDEX_WIDTH = (ENTRIES > 1) ? $clog2(ENTRIES) : 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic [INDEX_WIDTH-1:0]   i_select,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_last,
    output logic [ENTRIES-1:0]       o_valid,
    input  logic [ENTRIES-1:0]       i_ready,
    output logic [ENTRIES*WIDTH-1:0] o_data,
    output logic [ENTRIES-1:0]       o_last,
    output logic [COUNT_WIDTH-1:0]   o_drop_count
);

    //--------------------------------------------------------------------------
    // Packet lock state
    //--------------------------------------------------------------------------
    typedef enum logic [0:0] {
        OPEN   = 1'b0,
        LOCKED = 1'b1
    } lock_state_t;

    lock_state_t              lock_state;
    lock_state_t              lock_state_next;
    logic [INDEX_WIDTH-1:0]   locked_index;
    logic [INDEX_WIDTH-1:0]   locked_index_next;

    //--------------------------------------------------------------------------
    // Two-entry circular buffer
    //--------------------------------------------------------------------------
    logic [WIDTH-1:0]         buf_data [2];
    logic [1:0]               buf_last;
    logic [INDEX_WIDTH-1:0]   buf_dest [2];
    logic                     wr_ptr;
    logic                     rd_ptr;
    logic [1:0]               count;

    logic                     accept;
    logic                     push;
    logic                     pop;
    logic                     in_range;
    logic [INDEX_WIDTH-1:0]   beat_dest;

    logic                     head_valid;
    logic [WIDTH-1:0]         head_data;
    logic                     head_last;
    logic [INDEX_WIDTH-1:0]   head_dest;

    // o_ready comes only from the occupancy register. It does not depend on
    // i_valid or i_select, so the upstream sees no combinational path.
    assign o_ready   = (count != 2'd2);
    assign accept    = i_valid & o_ready;

    // Inside a packet, the captured destination overrides i_select.
    assign beat_dest = (lock_state == LOCKED) ? locked_index : i_select;

    // An index can only be out of range when ENTRIES is not a power of two.
    generate
        if (ENTRIES == (1 << INDEX_WIDTH)) begin : g_range_full
            assign in_range = 1'b1;
        end else begin : g_range_check
            localparam logic [INDEX_WIDTH:0] ENTRIES_EXT = (INDEX_WIDTH + 1)'(ENTRIES);
            assign in_range = ({1'b0, beat_dest} < ENTRIES_EXT);
        end
    endgenerate

    // Out-of-range beats are accepted but never written into the buffer.
    assign push = accept & in_range;

    assign head_valid = (count != 2'd0);
    assign head_data  = buf_data[rd_ptr];
    assign head_last  = buf_last[rd_ptr];
    assign head_dest  = buf_dest[rd_ptr];

    //--------------------------------------------------------------------------
    // Output lanes. Every lane carries the head payload. Only the lane
    // addressed by the head destination asserts valid.
    //--------------------------------------------------------------------------
    generate
        for (genvar k = 0; k < ENTRIES; k++) begin : g_lane
            assign o_valid[k]                = head_valid & (head_dest == INDEX_WIDTH'(k));
            assign o_data[k*WIDTH +: WIDTH]  = head_data;
            assign o_last[k]                 = head_last;
        end
    endgenerate

    // The head leaves only when its own destination is ready. A stalled
    // destination therefore blocks everything queued behind it.
    assign pop = |(o_valid & i_ready);

    //--------------------------------------------------------------------------
    // Lock FSM
    //--------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lock_state   <= OPEN;
            locked_index <= '0;
        end else begin
            lock_state   <= lock_state_next;
            locked_index <= locked_index_next;
        end
    end

    always_comb begin
        lock_state_next   = lock_state;
        locked_index_next = locked_index;
        if (accept) begin
            case (lock_state)
                OPEN: begin
                    // A single-beat packet never enters LOCKED.
                    if (!i_last) begin
                        lock_state_next   = LOCKED;
                        locked_index_next = i_select;
                    end
                end
                LOCKED: begin
                    if (i_last) begin
                        lock_state_next = OPEN;
                    end
                end
                default: lock_state_next = OPEN;
            endcase
        end
    end

    //--------------------------------------------------------------------------
    // Buffer storage and pointers
    //--------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < 2; i++) begin
                buf_data[i] <= '0;
                buf_dest[i] <= '0;
            end
            buf_last <= '0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            count    <= 2'd0;
        end else begin
            if (push) begin
                buf_data[wr_ptr] <= i_data;
                buf_last[wr_ptr] <= i_last;
                buf_dest[wr_ptr] <= beat_dest;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    //--------------------------------------------------------------------------
    // Dropped-beat counter
    //--------------------------------------------------------------------------
`ifdef PZBCM_STREAM_DEMUX_DROP_COUNTER_EN
    logic                   drop;
    logic [COUNT_WIDTH-1:0] drop_count;

    assign drop = accept & ~in_range;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            drop_count <= '0;
        end else if (drop && (drop_count != {COUNT_WIDTH{1'b1}})) begin
            drop_count <= drop_count + 1'b1;
        end
    end

    assign o_drop_count = drop_count;
`else
    assign o_drop_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pzbcm_stream_demux.sv
`default_nettype none
//==============================================================================
// Module      : tb_pzbcm_stream_demux
// Description : Directed self-checking bench for pzbcm_stream_demux. The
//               main instance has ENTRIES=4. A second instance with
//               ENTRIES=3 covers out-of-range destinations.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_pzbcm_stream_demux;

    localparam int W = 32;

`ifdef PZBCM_STREAM_DEMUX_DROP_COUNTER_EN
    localparam int EXP_DROP = 2;
`else
    localparam int EXP_DROP = 0;
`endif

    logic           clk = 1'b0;
    logic           rst_n;

    // ENTRIES = 4 instance
    logic           valid;
    logic           ready;
    logic [1:0]     sel;
    logic [W-1:0]   data;
    logic           last;
    logic [3:0]     ovalid;
    logic [3:0]     iready;
    logic [4*W-1:0] odata;
    logic [3:0]     olast;
    logic [15:0]    drop0;

    // ENTRIES = 3 instance
    logic           valid1;
    logic           ready1;
    logic [1:0]     sel1;
    logic [W-1:0]   data1;
    logic           last1;
    logic [2:0]     ovalid1;
    logic [2:0]     iready1;
    logic [3*W-1:0] odata1;
    logic [2:0]     olast1;
    logic [15:0]    drop1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pzbcm_stream_demux #(.WIDTH(W), .ENTRIES(4), .COUNT_WIDTH(16)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_valid      (valid),
        .o_ready      (ready),
        .i_select     (sel),
        .i_data       (data),
        .i_last       (last),
        .o_valid      (ovalid),
        .i_ready      (iready),
        .o_data       (odata),
        .o_last       (olast),
        .o_drop_count (drop0)
    );

    pzbcm_stream_demux #(.WIDTH(W), .ENTRIES(3), .COUNT_WIDTH(16)) dut3 (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_valid      (valid1),
        .o_ready      (ready1),
        .i_select     (sel1),
        .i_data       (data1),
        .i_last       (last1),
        .o_valid      (ovalid1),
        .i_ready      (iready1),
        .o_data       (odata1),
        .o_last       (olast1),
        .o_drop_count (drop1)
    );

    task automatic drive(input logic v, input logic [1:0] s, input logic [W-1:0] d, input logic l);
        valid = v;
        sel   = s;
        data  = d;
        last  = l;
    endtask

    task automatic test_reset;
        rst_n   = 1'b0;
        drive(1'b0, 2'd0, '0, 1'b0);
        iready  = 4'hF;
        valid1  = 1'b0;
        sel1    = 2'd0;
        data1   = '0;
        last1   = 1'b0;
        iready1 = 3'b111;
        repeat (3) @(negedge clk);
        checks++; if (ovalid !== 4'h0) begin failures++; $display("FAIL reset_valid got=%b exp=0000", ovalid); end
        checks++; if (olast !== 4'h0) begin failures++; $display("FAIL reset_last got=%b exp=0000", olast); end
        checks++; if (odata !== '0) begin failures++; $display("FAIL reset_data got=%h exp=0", odata); end
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ready); end
        checks++; if (drop0 !== 16'd0) begin failures++; $display("FAIL reset_drop got=%0d exp=0", drop0); end
        rst_n = 1'b1;
    endtask

    task automatic test_single_beats;
        iready = 4'hF;
        for (int s = 0; s < 4; s++) begin
            @(posedge clk); #1;
            drive(1'b1, 2'(s), W'(32'hA0 + s), 1'b1);
            @(posedge clk); #1;
            drive(1'b0, 2'd0, '0, 1'b0);
            @(negedge clk);
            checks++; if (ovalid !== 4'(1 << s)) begin failures++; $display("FAIL single_valid sel=%0d got=%b exp=%b", s, ovalid, 4'(1 << s)); end
            checks++; if (odata[s*W +: W] !== W'(32'hA0 + s)) begin failures++; $display("FAIL single_data sel=%0d got=%h exp=%h", s, odata[s*W +: W], 32'hA0 + s); end
            checks++; if (olast[s] !== 1'b1) begin failures++; $display("FAIL single_last sel=%0d got=%b exp=1", s, olast[s]); end
            checks++; if (ready !== 1'b1) begin failures++; $display("FAIL single_ready sel=%0d got=%b exp=1", s, ready); end
        end
        @(negedge clk);
        checks++; if (ovalid !== 4'h0) begin failures++; $display("FAIL single_drain got=%b exp=0000", ovalid); end
    endtask

    task automatic test_packet_lock;
        logic [1:0] beat_sel [3];
        beat_sel[0] = 2'd2;
        beat_sel[1] = 2'd0;
        beat_sel[2] = 2'd1;
        iready = 4'hF;
        @(posedge clk); #1;
        drive(1'b1, beat_sel[0], 32'hB0, 1'b0);
        for (int b = 1; b <= 3; b++) begin
            @(posedge clk); #1;
            if (b < 3) drive(1'b1, beat_sel[b], W'(32'hB0 + b), (b == 2));
            else       drive(1'b0, 2'd0, '0, 1'b0);
            @(negedge clk);
            checks++; if (ovalid !== 4'b0100) begin failures++; $display("FAIL pkt_valid beat=%0d got=%b exp=0100", b-1, ovalid); end
            checks++; if (odata[2*W +: W] !== W'(32'hB0 + b - 1)) begin failures++; $display("FAIL pkt_data beat=%0d got=%h exp=%h", b-1, odata[2*W +: W], 32'hB0 + b - 1); end
            checks++; if (olast[2] !== (b == 3)) begin failures++; $display("FAIL pkt_last beat=%0d got=%b exp=%b", b-1, olast[2], (b == 3)); end
        end
        // A new packet must sample i_select again.
        @(posedge clk); #1;
        drive(1'b1, 2'd3, 32'hB3, 1'b1);
        @(posedge clk); #1;
        drive(1'b0, 2'd0, '0, 1'b0);
        @(negedge clk);
        checks++; if (ovalid !== 4'b1000) begin failures++; $display("FAIL pkt_resample got=%b exp=1000", ovalid); end
        @(posedge clk);
    endtask

    task automatic test_backpressure;
        logic [W-1:0] got [$];
        int sent;
        int cyc;
        logic acc;
        logic popped;
        iready = 4'b1101;
        sent   = 0;
        @(posedge clk); #1;
        drive(1'b1, 2'd1, 32'hC0, 1'b1);
        @(posedge clk); #1;
        drive(1'b1, 2'd1, 32'hC1, 1'b1);
        @(posedge clk); #1;
        drive(1'b1, 2'd1, 32'hC2, 1'b1);
        sent = 2;
        repeat (2) begin
            @(negedge clk);
            checks++; if (ready !== 1'b0) begin failures++; $display("FAIL bp_full_ready got=%b exp=0", ready); end
            checks++; if (ovalid !== 4'b0010 || odata[W +: W] !== 32'hC0) begin failures++; $display("FAIL bp_head got=%b/%h exp=0010/c0", ovalid, odata[W +: W]); end
            @(posedge clk); #1;
        end
        iready = 4'hF;
        cyc = 0;
        while (got.size() < 4 && cyc < 20) begin
            @(negedge clk);
            acc    = valid & ready;
            popped = ovalid[1] & iready[1];
            if (popped) got.push_back(odata[W +: W]);
            @(posedge clk); #1;
            if (acc) begin
                sent++;
                if (sent < 4) drive(1'b1, 2'd1, W'(32'hC0 + sent), 1'b1);
                else          drive(1'b0, 2'd0, '0, 1'b0);
            end
            cyc++;
        end
        checks++; if (got.size() != 4) begin failures++; $display("FAIL bp_count got=%0d exp=4", got.size()); end
        for (int i = 0; i < got.size() && i < 4; i++) begin
            checks++; if (got[i] !== W'(32'hC0 + i)) begin failures++; $display("FAIL bp_order idx=%0d got=%h exp=%h", i, got[i], 32'hC0 + i); end
        end
        @(negedge clk);
        checks++; if (ovalid !== 4'h0) begin failures++; $display("FAIL bp_no_dup got=%b exp=0000", ovalid); end
    endtask

    task automatic test_out_of_range;
        @(posedge clk); #1;
        valid1 = 1'b1; sel1 = 2'd3; data1 = 32'hD0; last1 = 1'b0;
        @(negedge clk);
        checks++; if (ready1 !== 1'b1) begin failures++; $display("FAIL oor_ready0 got=%b exp=1", ready1); end
        @(posedge clk); #1;
        // The lock holds destination 3, so this in-range select is ignored.
        valid1 = 1'b1; sel1 = 2'd0; data1 = 32'hD1; last1 = 1'b1;
        @(negedge clk);
        checks++; if (ovalid1 !== 3'b000) begin failures++; $display("FAIL oor_valid0 got=%b exp=000", ovalid1); end
        checks++; if (ready1 !== 1'b1) begin failures++; $display("FAIL oor_ready1 got=%b exp=1", ready1); end
        @(posedge clk); #1;
        valid1 = 1'b1; sel1 = 2'd2; data1 = 32'hD2; last1 = 1'b1;
        @(negedge clk);
        checks++; if (ovalid1 !== 3'b000) begin failures++; $display("FAIL oor_valid1 got=%b exp=000", ovalid1); end
        checks++; if (drop1 !== 16'(EXP_DROP)) begin failures++; $display("FAIL oor_drop got=%0d exp=%0d", drop1, EXP_DROP); end
        @(posedge clk); #1;
        valid1 = 1'b0; last1 = 1'b0;
        @(negedge clk);
        checks++; if (ovalid1 !== 3'b100 || odata1[2*W +: W] !== 32'hD2) begin failures++; $display("FAIL oor_next got=%b/%h exp=100/d2", ovalid1, odata1[2*W +: W]); end
        checks++; if (drop1 !== 16'(EXP_DROP)) begin failures++; $display("FAIL oor_drop_hold got=%0d exp=%0d", drop1, EXP_DROP); end
        checks++; if (drop0 !== 16'd0) begin failures++; $display("FAIL oor_drop_main got=%0d exp=0", drop0); end
    endtask

    task automatic test_reset_mid_packet;
        iready = 4'b1011;
        @(posedge clk); #1;
        drive(1'b1, 2'd2, 32'hE9, 1'b0);
        @(posedge clk); #1;
        drive(1'b0, 2'd0, '0, 1'b0);
        @(negedge clk);
        checks++; if (ovalid !== 4'b0100) begin failures++; $display("FAIL mid_pre got=%b exp=0100", ovalid); end
        rst_n = 1'b0;
        #1;
        checks++; if (ovalid !== 4'h0) begin failures++; $display("FAIL mid_rst_valid got=%b exp=0000", ovalid); end
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL mid_rst_ready got=%b exp=1", ready); end
        @(negedge clk);
        rst_n  = 1'b1;
        iready = 4'hF;
        @(posedge clk); #1;
        drive(1'b1, 2'd1, 32'hE0, 1'b1);
        @(posedge clk); #1;
        drive(1'b0, 2'd0, '0, 1'b0);
        @(negedge clk);
        checks++; if (ovalid !== 4'b0010 || odata[W +: W] !== 32'hE0) begin failures++; $display("FAIL mid_after got=%b/%h exp=0010/e0", ovalid, odata[W +: W]); end
        @(posedge clk);
    endtask

    task automatic test_back_to_back;
        iready = 4'hF;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            drive(1'b1, 2'd0, W'(32'hF0 + i), (i == 7));
            @(negedge clk);
            checks++; if (ready !== 1'b1) begin failures++; $display("FAIL b2b_ready cyc=%0d got=%b exp=1", i, ready); end
            if (i > 0) begin
                checks++; if (ovalid !== 4'b0001 || odata[W-1:0] !== W'(32'hF0 + i - 1)) begin failures++; $display("FAIL b2b_out cyc=%0d got=%b/%h exp=0001/%h", i, ovalid, odata[W-1:0], 32'hF0 + i - 1); end
            end
        end
        @(posedge clk); #1;
        drive(1'b0, 2'd0, '0, 1'b0);
        @(negedge clk);
        checks++; if (ovalid !== 4'b0001 || odata[W-1:0] !== 32'hF7 || olast[0] !== 1'b1) begin failures++; $display("FAIL b2b_tail got=%b/%h/%b exp=0001/f7/1", ovalid, odata[W-1:0], olast[0]); end
        @(negedge clk);
        checks++; if (ovalid !== 4'h0) begin failures++; $display("FAIL b2b_drain got=%b exp=0000", ovalid); end
    endtask

    initial begin
        test_reset();
        test_single_beats();
        test_packet_lock();
        test_backpressure();
        test_out_of_range();
        test_reset_mid_packet();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
